rtc_ts_capture: RTL and testbench

// Timestamp capture unit: the reader side of the rtc_timer ToD outputs.

---
 rtl/rtc_ts_capture_if.sv | 32 +++
 rtl/rtc_ts_capture.sv | 152 +++++++++++++++
 tb/tb_rtc_ts_capture.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_ts_capture_if.sv
// Host-side port bundle of the timestamp capture unit.
//   master : the host. It drives rd_en and ovf_clr, and it reads the queue head and the status.
//   slave  : rtc_ts_capture. It drives q_valid, q_ns, q_sec, q_cnt, ovf and drop_cnt.
// The signals are:
//   rd_en    pop the head entry (ignored while q_valid=0)
//   ovf_clr  clear ovf and drop_cnt
//   q_valid  queue non-empty; q_ns/q_sec show the head entry (first-word fall-through)
//   q_cnt    entries held, DEPTH_LOG2+1 bits
//   ovf      sticky drop flag
//   drop_cnt dropped events, saturating at 255
interface rtc_ts_capture_if #(
  parameter int DEPTH_LOG2 = 3
);
  logic                rd_en;
  logic                ovf_clr;
  logic                q_valid;
  logic [37:0]         q_ns;
  logic [47:0]         q_sec;
  logic [DEPTH_LOG2:0] q_cnt;
  logic                ovf;
  logic [7:0]          drop_cnt;

  modport master (
    output rd_en, ovf_clr,
    input  q_valid, q_ns, q_sec, q_cnt, ovf, drop_cnt
  );

  modport slave (
    input  rd_en, ovf_clr,
    output q_valid, q_ns, q_sec, q_cnt, ovf, drop_cnt
  );
endinterface

// File: rtl/rtc_ts_capture.sv
// Timestamp capture unit. It sits beside rtc_timer in the same clk domain.
//
// A rising edge on the asynchronous input evt_in samples {time_reg_sec, time_reg_ns}.
// The stamp is queued in a FIFO for the host.
// Optional feature macro: RTC_TSU_LAT_COMP_EN.
//   When it is defined, the stamp is moved back by LAT_COMP (borrowing a second when needed).
//   This adds one extra pipeline stage.
//
// Ports:
//   clk              RTC clock
//   rst              asynchronous reset, active-low
//   time_reg_ns      ToD ns[37:8] + fraction[7:0]
//   time_reg_sec     ToD seconds
//   time_acc_modulo  ns wrap value, same format; used only with latency compensation
//   evt_in           asynchronous event; a rising edge captures a stamp
//   host             rtc_ts_capture_if.slave. It carries the read, status and queue-head signals.
module rtc_ts_capture #(
  parameter int          DEPTH_LOG2 = 3,
  // 24 ns, zero fraction
  parameter logic [37:0] LAT_COMP   = {30'd24, 8'd0}
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [37:0] time_reg_ns,
  input  logic [47:0] time_reg_sec,
  input  logic [37:0] time_acc_modulo,
  input  logic        evt_in,
  rtc_ts_capture_if.slave host
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  // Event synchroniser and rising-edge detector.
  logic s1, s2, s3;
  logic cap;

  // NOTE: state registers use non-blocking assignments.
  //       Then every flop samples pre-edge values, whatever order the blocks evaluate in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= evt_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign cap = s2 & ~s3;

  // Write request and the stamp that goes with it.
  logic        wr_req;
  logic [37:0] wr_ns;
  logic [47:0] wr_sec;

`ifdef RTC_TSU_LAT_COMP_EN
  logic [37:0] comp_ns;
  logic [47:0] comp_sec;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned.
  //       An unassigned path would infer a latch.
  always_comb begin
    comp_ns  = time_reg_ns - LAT_COMP;
    comp_sec = time_reg_sec;
    if (time_reg_ns < LAT_COMP) begin
      // Borrow one second. Second 0 wraps to all-ones.
      comp_ns  = time_reg_ns + time_acc_modulo - LAT_COMP;
      comp_sec = time_reg_sec - 48'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_req <= 1'b0;
      wr_ns  <= '0;
      wr_sec <= '0;
    end else begin
      wr_req <= cap;
      wr_ns  <= comp_ns;
      wr_sec <= comp_sec;
    end
  end
`else
  logic unused_cfg;

  assign wr_req     = cap;
  assign wr_ns      = time_reg_ns;
  assign wr_sec     = time_reg_sec;
  assign unused_cfg = ^{time_acc_modulo, LAT_COMP};
`endif

  // FIFO
  logic [85:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  ovf_q;
  logic [7:0]            drop_q;
  logic                  full, pop, push, drop;

  assign full = (count == FULL_CNT);
  assign pop  = host.rd_en & (count != '0);
  // When the FIFO is full, a pop in the same cycle frees the slot being written.
  assign push = wr_req & (~full | pop);
  assign drop = wr_req & full & ~pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // A drop in the same cycle as ovf_clr wins.
      // The counter then restarts at 1 rather than adding onto the old value.
      if (drop) begin
        ovf_q <= 1'b1;
        if (host.ovf_clr)          drop_q <= 8'd1;
        else if (drop_q != 8'hFF)  drop_q <= drop_q + 8'd1;
      end else if (host.ovf_clr) begin
        ovf_q  <= 1'b0;
        drop_q <= '0;
      end
    end
  end

  // NOTE: the storage array has no reset.
  //       Slots are only read once written, and empty-queue outputs are forced to zero below.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wr_sec, wr_ns};
  end

  assign host.q_valid  = (count != '0);
  assign host.q_ns     = host.q_valid ? mem[rd_ptr][37:0]  : '0;
  assign host.q_sec    = host.q_valid ? mem[rd_ptr][85:38] : '0;
  assign host.q_cnt    = count;
  assign host.ovf      = ovf_q;
  assign host.drop_cnt = drop_q;

endmodule

// File: tb/tb_rtc_ts_capture.sv
// Self-checking bench for rtc_ts_capture.
// The bench owns a ToD model that steps 8 ns per clock with a fixed fraction and wraps at 1e9 ns.
// Expected stamps are derived from that model when an event is driven.
// They are queued, then compared against the queue head when the DUT presents it.
module tb_rtc_ts_capture;

  localparam int DEPTH_LOG2 = 3;
  localparam int DEPTH      = 8;
`ifdef RTC_TSU_LAT_COMP_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam logic [29:0] NS_WRAP = 30'd1_000_000_000;
  localparam logic [7:0]  FRAC    = 8'h5A;

  typedef struct packed {
    logic [47:0] sec;
    logic [37:0] ns;
  } stamp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        evt_in;
  logic [37:0] time_reg_ns;
  logic [47:0] time_reg_sec;
  logic [37:0] time_acc_modulo;

  rtc_ts_capture_if #(.DEPTH_LOG2(DEPTH_LOG2)) host ();

  rtc_ts_capture #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk             (clk),
    .rst             (rst),
    .time_reg_ns     (time_reg_ns),
    .time_reg_sec    (time_reg_sec),
    .time_acc_modulo (time_acc_modulo),
    .evt_in          (evt_in),
    .host            (host)
  );

  always #5 clk = ~clk;

  int     errors = 0;
  int     checks = 0;
  stamp_t exp_q[$];

  // ToD model.
  stamp_t now_t;
  stamp_t load_val;
  bit     load_pending = 1'b0;

  assign time_reg_ns     = now_t.ns;
  assign time_reg_sec    = now_t.sec;
  assign time_acc_modulo = {NS_WRAP, 8'd0};

  function automatic stamp_t step(stamp_t s, int n);
    for (int i = 0; i < n; i++) begin
      if (s.ns[37:8] + 30'd8 >= NS_WRAP) begin
        s.ns[37:8] = s.ns[37:8] + 30'd8 - NS_WRAP;
        s.sec      = s.sec + 48'd1;
      end else begin
        s.ns[37:8] = s.ns[37:8] + 30'd8;
      end
    end
    return s;
  endfunction

  // What the DUT should store for a stamp taken at a given ToD.
  function automatic stamp_t expected_of(stamp_t raw);
    stamp_t e = raw;
`ifdef RTC_TSU_LAT_COMP_EN
    if (raw.ns[37:8] >= 30'd24) begin
      e.ns[37:8] = raw.ns[37:8] - 30'd24;
    end else begin
      e.ns[37:8] = raw.ns[37:8] + NS_WRAP - 30'd24;
      e.sec      = raw.sec - 48'd1;
    end
`endif
    return e;
  endfunction

  initial begin
    now_t = {48'd0, 30'd0, FRAC};
    forever begin
      @(negedge clk);
      if (load_pending) begin
        now_t        = load_val;
        load_pending = 1'b0;
      end else begin
        now_t = step(now_t, 1);
      end
    end
  end

  // Stimulus always resumes just after a falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_time(input logic [47:0] sec, input logic [29:0] ns_int);
    load_val     = {sec, ns_int, FRAC};
    load_pending = 1'b1;
    cyc(1);
  endtask

  // One event, spaced so that the entry is written and the input is low long enough afterwards.
  task automatic fire_evt(input bit accept);
    if (accept) exp_q.push_back(expected_of(step(now_t, 2)));
    evt_in = 1'b1;
    cyc(2);
    evt_in = 1'b0;
    cyc(LAT + 1);
  endtask

  // Compare the head with the scoreboard, then pop it.
  task automatic pop_check(input string name);
    stamp_t exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, q_valid=%0b", name, host.q_valid);
    end else begin
      exp = exp_q.pop_front();
      if (host.q_valid !== 1'b1 || host.q_ns !== exp.ns || host.q_sec !== exp.sec) begin
        errors++;
        $display("FAIL %s: got valid=%0b sec=%0d ns=%0h expected valid=1 sec=%0d ns=%0h",
                 name, host.q_valid, host.q_sec, host.q_ns, exp.sec, exp.ns);
      end
    end
    host.rd_en = 1'b1;
    cyc(1);
    host.rd_en = 1'b0;
  endtask

  task automatic check_status(input string name, input logic [DEPTH_LOG2:0] cnt,
                              input logic ovf, input logic [7:0] drops);
    checks++;
    if (host.q_cnt !== cnt || host.ovf !== ovf || host.drop_cnt !== drops
        || host.q_valid !== (cnt != 0)) begin
      errors++;
      $display("FAIL %s: got cnt=%0d valid=%0b ovf=%0b drop=%0d expected cnt=%0d ovf=%0b drop=%0d",
               name, host.q_cnt, host.q_valid, host.ovf, host.drop_cnt, cnt, ovf, drops);
    end
  endtask

  task automatic test_reset();
    rst          = 1'b0;
    evt_in       = 1'b0;
    host.rd_en   = 1'b0;
    host.ovf_clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      evt_in = ~evt_in;
      cyc(1);
      check_status("reset_hold", '0, 1'b0, 8'd0);
    end
    evt_in = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(4);
    check_status("reset_release", '0, 1'b0, 8'd0);
  endtask

  task automatic test_single_capture();
    set_time(48'd10, 30'd999_999_960);
    exp_q.push_back(expected_of(step(now_t, 2)));
    evt_in = 1'b1;
    cyc(LAT);
    checks++;
    if (host.q_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: got q_valid=%0b expected 0", host.q_valid);
    end
    cyc(1);
    checks++;
    if (host.q_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_due: got q_valid=%0b expected 1", host.q_valid);
    end
    evt_in = 1'b0;
`ifndef RTC_TSU_LAT_COMP_EN
    checks++;
    if (host.q_ns[37:8] !== 30'd999_999_976 || host.q_sec !== 48'd10) begin
      errors++;
      $display("FAIL single_value: got sec=%0d ns=%0d expected sec=10 ns=999999976",
               host.q_sec, host.q_ns[37:8]);
    end
`endif
    pop_check("single_pop");
    check_status("single_empty", '0, 1'b0, 8'd0);
    // A read while empty must not move the pointers.
    host.rd_en = 1'b1;
    cyc(2);
    host.rd_en = 1'b0;
    check_status("empty_read", '0, 1'b0, 8'd0);
    cyc(2);
    fire_evt(1'b1);
    check_status("after_empty_read", 4'd1, 1'b0, 8'd0);
    pop_check("after_empty_read_pop");
  endtask

  task automatic test_fill_overflow();
    set_time(48'd20, 30'd100);
    for (int i = 0; i < 10; i++) fire_evt(i < DEPTH);
    check_status("overflow", 4'd8, 1'b1, 8'd2);
    for (int i = 0; i < DEPTH; i++) begin
      check_status("drain_cnt", 4'(DEPTH - i), 1'b1, 8'd2);
      pop_check("drain_order");
    end
    host.ovf_clr = 1'b1;
    cyc(1);
    host.ovf_clr = 1'b0;
    check_status("ovf_clear", '0, 1'b0, 8'd0);
  endtask

  task automatic test_back_to_back();
    stamp_t nxt;
    for (int i = 0; i < DEPTH; i++) fire_evt(1'b1);
    check_status("refill", 4'd8, 1'b0, 8'd0);
    // The event's write edge coincides with a pop of the head.
    nxt    = expected_of(step(now_t, 2));
    evt_in = 1'b1;
    cyc(LAT);
    pop_check("pop_push_head");
    exp_q.push_back(nxt);
    evt_in = 1'b0;
    check_status("pop_push", 4'd8, 1'b0, 8'd0);
    cyc(2);
    fire_evt(1'b0);
    check_status("drop_one", 4'd8, 1'b1, 8'd1);
    // The write edge of a dropped event coincides with ovf_clr, and the drop must win.
    evt_in = 1'b1;
    cyc(LAT);
    host.ovf_clr = 1'b1;
    cyc(1);
    host.ovf_clr = 1'b0;
    evt_in       = 1'b0;
    check_status("drop_vs_clr", 4'd8, 1'b1, 8'd1);
    cyc(2);
    for (int i = 0; i < DEPTH; i++) pop_check("b2b_drain");
    host.ovf_clr = 1'b1;
    cyc(1);
    host.ovf_clr = 1'b0;
    check_status("b2b_end", '0, 1'b0, 8'd0);
  endtask

`ifdef RTC_TSU_LAT_COMP_EN
  task automatic check_comp(input string name, input logic [47:0] sec, input logic [29:0] ns_int);
    checks++;
    if (host.q_valid !== 1'b1 || host.q_ns[37:8] !== ns_int || host.q_sec !== sec) begin
      errors++;
      $display("FAIL %s: got sec=%0h ns=%0d expected sec=%0h ns=%0d",
               name, host.q_sec, host.q_ns[37:8], sec, ns_int);
    end
  endtask

  task automatic test_lat_comp();
    set_time(48'd10, 30'd999_999_992);
    fire_evt(1'b1);
    check_comp("comp_borrow", 48'd10, 30'd999_999_984);
    pop_check("comp_borrow_pop");
    set_time(48'd11, 30'd484);
    fire_evt(1'b1);
    check_comp("comp_plain", 48'd11, 30'd476);
    pop_check("comp_plain_pop");
    set_time(48'd0, 30'd0);
    fire_evt(1'b1);
    check_comp("comp_sec_wrap", 48'hFFFF_FFFF_FFFF, 30'd999_999_992);
    pop_check("comp_sec_wrap_pop");
  endtask
`endif

  task automatic test_reset_mid_event();
    evt_in = 1'b1;
    cyc(1);
    rst    = 1'b0;
    evt_in = 1'b0;
    cyc(3);
    check_status("mid_reset_hold", '0, 1'b0, 8'd0);
    rst = 1'b1;
    cyc(6);
    check_status("mid_reset_after", '0, 1'b0, 8'd0);
  endtask

  initial begin
    test_reset();
    test_single_capture();
    test_fill_overflow();
    test_back_to_back();
`ifdef RTC_TSU_LAT_COMP_EN
    test_lat_comp();
`endif
    test_reset_mid_event();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
